gt_victim_cache: RTL and testbench
==================================

// Module: gt_victim_cache
// PURPOSE
// - Small fully-associative victim cache behind the direct-mapped L1 (32 x 256-bit lines).
// - Accepts lines evicted by the L1, holds them, and answers L1 miss lookups; on hit returns the
//   full line to L1 (its memDataFromVictim input) and drops its own copy (swap semantics).
// - Clean lines only: no write-back to main memory; overwritten/replaced lines are discarded.
// PARAMETERS
// - ENTRIES   8    number of victim lines (power of 2, 2..32)
// - LINE_W    256  line width in bits
// - ADDR_W    32   byte address width
// - OFFSET_W  5    byte-offset bits; line tag = addr[ADDR_W-1:OFFSET_W] (27 bits by default)
// PORTS
// - CLK         in   1        clock, all state on posedge
// - RST_N       in   1        asynchronous active-low reset
// - evictValid  in   1        L1 presents an evicted line this cycle (single-cycle pulse, no backpressure)
// - evictAddr   in   ADDR_W   any byte address inside the evicted line
// - evictData   in   LINE_W   evicted line contents
// - reqValid    in   1        L1 lookup request; accepted when reqValid && reqReady
// - reqAddr     in   ADDR_W   lookup byte address
// - reqReady    out  1        block can accept a lookup this cycle
// - respValid   out  1        one-cycle pulse: respHit/respData valid
// - respHit     out  1        lookup found the line
// - respData    out  LINE_W   hit line; all zeros on miss
// BEHAVIOUR
// - Reset (async, RST_N=0): all valid bits 0, replace pointer 0, reqReady=1, respValid=0,
//   respHit=0, respData=0; stats counters 0 when compiled in. Mid-operation reset abandons any
//   pending response (no respValid after release).
// - FSM: IDLE (reqReady=1) -> RESP on accepted request; RESP (reqReady=0, respValid=1) -> IDLE.
//   Latency: request accepted at edge N, response visible for exactly the cycle after edge N.
//   Back-to-back lookups therefore run at one per two cycles.
// - Lookup: in IDLE, tag compared against all valid entries (state before the edge). Hit: data
//   registered into respData, respHit=1, matched entry invalidated at the same edge. Miss:
//   respHit=0, respData=0. At most one entry may match (guaranteed by insert rule).
// - Insert on evictValid (any state): tag match on a valid entry -> overwrite that entry in place;
//   else lowest-index invalid entry; else entry at replace pointer, pointer increments mod
//   ENTRIES (wraps ENTRIES-1 -> 0). Pointer advances only when a valid entry is replaced.
// - evictData of all zeros is still stored (valid bit, not data, marks occupancy).
// - Simultaneous insert and hitting lookup, same edge: lookup returns the old data; if the insert
//   targets the invalidated slot (same tag) the insert wins and the entry stays valid with new
//   data. Different tag: invalidation and insert both take effect; insert may not pick the slot
//   being freed in that cycle (free-slot search uses pre-edge valid bits).
// - Simultaneous insert and missing lookup: response is a miss even if evictAddr tag equals reqAddr tag.
// - reqValid in RESP is ignored (not accepted); L1 must hold it until reqReady.
// CONFIGURATION
// - GT_VICTIM_STATS_EN defined: adds outputs hitCount[31:0], missCount[31:0], replaceCount[31:0];
//   increment on lookup hit, lookup miss, and replacement of a valid non-matching entry; wrap at
//   2^32; reset to 0.
// - Undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - Reset then lookup 0x0000_1000 -> respValid 1 cycle later, respHit=0, respData=0; reqReady low in RESP.
// - Evict 0x0000_1004 data D1; lookup 0x0000_101F -> respHit=1, respData=D1; repeat lookup -> miss.
// - Evict 9 distinct lines A0..A8 (ENTRIES=8) -> A0 replaced; lookup A0 miss, A1..A8 hit; with
//   stats, replaceCount=1.
// - Evict 0x200 data D1 then 0x210 data D2 (same line) -> single entry; lookup returns D2, then miss.
// - Same cycle: lookup 0x300 (present, data D1) and evict 0x300 data D3 -> response D1 hit; next
//   lookup 0x300 hits with D3.
// - Assert RST_N low during RESP -> respValid drops immediately, all entries invalid, no later respValid.

Source files
------------

// File: rtl/gt_victim_cache.sv
// gt_victim_cache: fully-associative clean victim cache behind the L1.
// Optional stats counters: define GT_VICTIM_STATS_EN.
module gt_victim_cache #(
  parameter int ENTRIES  = 8,
  parameter int LINE_W   = 256,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              evictValid,
  input  logic [ADDR_W-1:0] evictAddr,
  input  logic [LINE_W-1:0] evictData,
  input  logic              reqValid,
  input  logic [ADDR_W-1:0] reqAddr,
  output logic              reqReady,
  output logic              respValid,
  output logic              respHit,
  output logic [LINE_W-1:0] respData
`ifdef GT_VICTIM_STATS_EN
  ,
  output logic [31:0]       hitCount,
  output logic [31:0]       missCount,
  output logic [31:0]       replaceCount
`endif
);

  localparam int TAG_W = ADDR_W - OFFSET_W;
  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t stateQ;
  state_t stateD;

  logic [ENTRIES-1:0] validQ;
  logic [TAG_W-1:0]   tagQ  [ENTRIES];
  logic [LINE_W-1:0]  dataQ [ENTRIES];
  logic [IDX_W-1:0]   replPtrQ;

  logic [TAG_W-1:0] reqTag;
  logic [TAG_W-1:0] evTag;
  logic             unusedLow;

  logic             hitAny;
  logic [IDX_W-1:0] hitIdx;
  logic             matchAny;
  logic [IDX_W-1:0] matchIdx;
  logic             freeAny;
  logic [IDX_W-1:0] freeIdx;
  logic [IDX_W-1:0] insIdx;
  logic             doReplace;
  logic             accept;
  logic             lookupHit;

  assign reqTag    = reqAddr[ADDR_W-1:OFFSET_W];
  assign evTag     = evictAddr[ADDR_W-1:OFFSET_W];
  assign unusedLow = ^{reqAddr[OFFSET_W-1:0], evictAddr[OFFSET_W-1:0]};

  // Lookup tag match against pre-edge valid entries
  always_comb begin
    hitAny = 1'b0;
    hitIdx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (validQ[i] && tagQ[i] == reqTag) begin
        hitAny = 1'b1;
        hitIdx = IDX_W'(i);
      end
    end
  end

  // Insert slot: same-tag entry, else lowest free, else replace pointer
  always_comb begin
    matchAny = 1'b0;
    matchIdx = '0;
    freeAny  = 1'b0;
    freeIdx  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (validQ[i] && tagQ[i] == evTag) begin
        matchAny = 1'b1;
        matchIdx = IDX_W'(i);
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!validQ[i]) begin
        freeAny = 1'b1;
        freeIdx = IDX_W'(i);
      end
    end
    insIdx = replPtrQ;
    if (matchAny) begin
      insIdx = matchIdx;
    end else if (freeAny) begin
      insIdx = freeIdx;
    end
    doReplace = evictValid && !matchAny && !freeAny;
  end

  assign accept    = reqValid && reqReady;
  assign lookupHit = accept && hitAny;

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    stateD    = stateQ;
    reqReady  = 1'b0;
    respValid = 1'b0;
    unique case (stateQ)
      IDLE: begin
        reqReady = 1'b1;
        if (reqValid) begin
          stateD = RESP;
        end
      end
      RESP: begin
        respValid = 1'b1;
        stateD    = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  // Valid bits, tags and replace pointer; insert beats invalidation
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      validQ   <= '0;
      replPtrQ <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tagQ[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (evictValid && insIdx == IDX_W'(i)) begin
          validQ[i] <= 1'b1;
          tagQ[i]   <= evTag;
        end else if (lookupHit && hitIdx == IDX_W'(i)) begin
          validQ[i] <= 1'b0;
        end
      end
      if (doReplace) begin
        replPtrQ <= replPtrQ + 1'b1;
      end
    end
  end

  // Line storage; occupancy is tracked by validQ only
  always_ff @(posedge CLK) begin
    if (evictValid) begin
      dataQ[insIdx] <= evictData;
    end
  end

  // Response registers, zero whenever no hit was just accepted
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      respHit  <= 1'b0;
      respData <= '0;
    end else begin
      respHit  <= lookupHit;
      respData <= lookupHit ? dataQ[hitIdx] : '0;
    end
  end

`ifdef GT_VICTIM_STATS_EN
  // Event counters, free-running with wrap
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hitCount     <= '0;
      missCount    <= '0;
      replaceCount <= '0;
    end else begin
      if (lookupHit) begin
        hitCount <= hitCount + 32'd1;
      end
      if (accept && !hitAny) begin
        missCount <= missCount + 32'd1;
      end
      if (doReplace) begin
        replaceCount <= replaceCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gt_victim_cache.sv
// tb_gt_victim_cache: scoreboard bench for gt_victim_cache.
// Stats ports are checked when GT_VICTIM_STATS_EN is defined.
module tb_gt_victim_cache;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              CLK;
  logic              RST_N;
  logic              evictValid;
  logic [ADDR_W-1:0] evictAddr;
  logic [LINE_W-1:0] evictData;
  logic              reqValid;
  logic [ADDR_W-1:0] reqAddr;
  logic              reqReady;
  logic              respValid;
  logic              respHit;
  logic [LINE_W-1:0] respData;
`ifdef GT_VICTIM_STATS_EN
  logic [31:0]       hitCount;
  logic [31:0]       missCount;
  logic [31:0]       replaceCount;
`endif

  gt_victim_cache dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .evictValid   (evictValid),
    .evictAddr    (evictAddr),
    .evictData    (evictData),
    .reqValid     (reqValid),
    .reqAddr      (reqAddr),
    .reqReady     (reqReady),
    .respValid    (respValid),
    .respHit      (respHit),
    .respData     (respData)
`ifdef GT_VICTIM_STATS_EN
    ,
    .hitCount     (hitCount),
    .missCount    (missCount),
    .replaceCount (replaceCount)
`endif
  );

  typedef struct packed {
    logic              hit;
    logic [LINE_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   expHits  = 0;
  int   expMiss  = 0;

  logic [LINE_W-1:0] d1;
  logic [LINE_W-1:0] d2;
  logic [LINE_W-1:0] d3;
  logic [LINE_W-1:0] d4;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop one expectation per response pulse
  always @(negedge CLK) begin
    if (RST_N && respValid) begin
      if (sb.size() == 0) begin
        check("unexpResp", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("respHit", LINE_W'(respHit), LINE_W'(e.hit));
        check("respData", respData, e.data);
      end
      check("rdyInResp", LINE_W'(reqReady), 0);
    end
  end

  function automatic logic [LINE_W-1:0] mkLine(input logic [31:0] s);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < LINE_W / 32; k++) begin
      l[k*32 +: 32] = s ^ (32'h0101_0101 * k);
    end
    return l;
  endfunction

  // All tasks start and end one time unit after a rising edge
  task automatic evict(input logic [31:0] a, input logic [LINE_W-1:0] d);
    evictValid = 1'b1;
    evictAddr  = a;
    evictData  = d;
    @(posedge CLK);
    #1;
    evictValid = 1'b0;
  endtask

  task automatic pushExp(input logic h, input logic [LINE_W-1:0] d);
    exp_t e;
    e.hit  = h;
    e.data = h ? d : '0;
    sb.push_back(e);
    if (h) expHits++;
    else expMiss++;
  endtask

  task automatic waitResp();
    @(negedge CLK);
    check("latency", LINE_W'(respValid), 1);
    @(posedge CLK);
    #1;
  endtask

  task automatic lookup(input logic [31:0] a,
                        input logic h,
                        input logic [LINE_W-1:0] d);
    bit ok = 0;
    reqValid = 1'b1;
    reqAddr  = a;
    pushExp(h, d);
    for (int n = 0; n < 10 && !ok; n++) begin
      if (reqReady) begin
        ok = 1;
      end
      @(posedge CLK);
      #1;
    end
    reqValid = 1'b0;
    if (!ok) begin
      check("acceptTimeout", 0, 1);
    end else begin
      @(negedge CLK);
      check("latency", LINE_W'(respValid), 1);
      @(posedge CLK);
      #1;
    end
  endtask

  // Lookup and evict driven in the same cycle while IDLE
  task automatic both(input logic [31:0] ra, input logic [31:0] ea,
                      input logic [LINE_W-1:0] ed,
                      input logic h, input logic [LINE_W-1:0] d);
    check("bothIdle", LINE_W'(reqReady), 1);
    reqValid   = 1'b1;
    reqAddr    = ra;
    evictValid = 1'b1;
    evictAddr  = ea;
    evictData  = ed;
    pushExp(h, d);
    @(posedge CLK);
    #1;
    reqValid   = 1'b0;
    evictValid = 1'b0;
    waitResp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    d1 = mkLine(32'h1111_1111);
    d2 = mkLine(32'h2222_2222);
    d3 = mkLine(32'h3333_3333);
    d4 = mkLine(32'h4444_4444);
    RST_N      = 1'b0;
    evictValid = 1'b0;
    evictAddr  = '0;
    evictData  = '0;
    reqValid   = 1'b0;
    reqAddr    = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rstReady", LINE_W'(reqReady), 1);
    check("rstRespV", LINE_W'(respValid), 0);
    check("rstRespH", LINE_W'(respHit), 0);
    check("rstRespD", respData, 0);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    lookup(32'h0000_1000, 0, 0);

    evict(32'h0000_1004, d1);
    lookup(32'h0000_101F, 1, d1);
    lookup(32'h0000_101F, 0, 0);

    for (int i = 0; i < 9; i++) begin
      evict(32'h0001_0000 + i * 32'h20, mkLine(32'hA000_0000 + i));
    end
    lookup(32'h0001_0000, 0, 0);
    for (int i = 1; i < 9; i++) begin
      lookup(32'h0001_0000 + i * 32'h20, 1, mkLine(32'hA000_0000 + i));
    end
`ifdef GT_VICTIM_STATS_EN
    check("replaceCount", LINE_W'(replaceCount), 1);
`endif

    evict(32'h0000_0200, d1);
    evict(32'h0000_0210, d2);
    lookup(32'h0000_0200, 1, d2);
    lookup(32'h0000_0200, 0, 0);

    evict(32'h0000_0300, d1);
    both(32'h0000_0300, 32'h0000_0300, d3, 1, d1);
    lookup(32'h0000_0300, 1, d3);

    evict(32'h0000_0400, '0);
    lookup(32'h0000_0400, 1, '0);
    lookup(32'h0000_0400, 0, 0);

    evict(32'h0000_0500, d1);
    both(32'h0000_0500, 32'h0000_0520, d2, 1, d1);
    lookup(32'h0000_0520, 1, d2);
    lookup(32'h0000_0500, 0, 0);

    both(32'h0000_0600, 32'h0000_0600, d4, 0, 0);
    lookup(32'h0000_0600, 1, d4);

`ifdef GT_VICTIM_STATS_EN
    check("hitCount", LINE_W'(hitCount), LINE_W'(expHits));
    check("missCount", LINE_W'(missCount), LINE_W'(expMiss));
`endif

    evict(32'h0000_0700, d1);
    reqValid = 1'b1;
    reqAddr  = 32'h0000_0700;
    @(posedge CLK);
    #1;
    reqValid = 1'b0;
    check("preRstRespV", LINE_W'(respValid), 1);
    RST_N = 1'b0;
    #1;
    check("midRstRespV", LINE_W'(respValid), 0);
    check("midRstRespD", respData, 0);
    check("midRstReady", LINE_W'(reqReady), 1);
`ifdef GT_VICTIM_STATS_EN
    check("rstHitCount", LINE_W'(hitCount), 0);
`endif
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    lookup(32'h0000_0700, 0, 0);
    lookup(32'h0000_0600, 0, 0);

    repeat (3) @(posedge CLK);
    check("sbEmpty", LINE_W'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
